// File: rtl/dmem_stage.sv
// Data-memory stage: byte-addressed little-endian store with a fixed access wait,
// one request in flight, and a valid/ready handshake on both sides.
module dmem_stage #(
  parameter int DATA_W  = 64,
  parameter int DEPTH_B = 1024,
  parameter int WAIT    = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        icode_i,
  input  logic [DATA_W-1:0] valA_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valP_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] valM_o,
  output logic [3:0]        icode_o,
  output logic              dmem_error_o
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH_B);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  function automatic logic is_wr(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h8, 4'hA: is_wr = 1'b1;
      default:          is_wr = 1'b0;
    endcase
  endfunction

  function automatic logic is_rd(input logic [3:0] ic);
    case (ic)
      4'h5, 4'h9, 4'hB: is_rd = 1'b1;
      default:          is_rd = 1'b0;
    endcase
  endfunction

  // popq and ret address the stack through valA rather than valE
  function automatic logic addr_from_a(input logic [3:0] ic);
    case (ic)
      4'h9, 4'hB: addr_from_a = 1'b1;
      default:    addr_from_a = 1'b0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [3:0]        icode_q;
  logic [DATA_W-1:0] valA_q, valE_q, valP_q, valM_q;
  logic              err_q;
  logic [7:0]        mem_q [DEPTH_B] = '{default: 8'h00};

  logic              accept_s, do_access_s, addr_err_s;
  logic [DATA_W-1:0] addr_s, rdata_s, wdata_s;
  logic [DATA_W:0]   end_s;
  logic [AW-1:0]     idx_s;

  assign accept_s    = valid_i && (state_q == IDLE);
  assign do_access_s = (state_q == ACCESS) && (cnt_q == 3'd0);
  assign addr_s      = addr_from_a(icode_q) ? valA_q : valE_q;
  assign wdata_s     = (icode_q == 4'h8) ? valP_q : valA_q;
  // one extra bit so a huge address cannot wrap back into range
  assign end_s       = {1'b0, addr_s} + (DATA_W+1)'(NB);
  assign addr_err_s  = end_s > (DATA_W+1)'(DEPTH_B);
  assign idx_s       = addr_s[AW-1:0];

  // Little-endian word assembly from consecutive bytes
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < NB; i++) begin
      rdata_s[8*i +: 8] = mem_q[idx_s + AW'(i)];
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = (is_wr(icode_i) || is_rd(icode_i)) ? ACCESS : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE:    ready_o = 1'b1;
      RESP:    valid_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  // Request capture, wait counter and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q   <= 3'd0;
      icode_q <= 4'h0;
      valA_q  <= '0;
      valE_q  <= '0;
      valP_q  <= '0;
      valM_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept_s) begin
      cnt_q   <= 3'(WAIT);
      icode_q <= icode_i;
      valA_q  <= valA_i;
      valE_q  <= valE_i;
      valP_q  <= valP_i;
      valM_q  <= '0;
      err_q   <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end else begin
        err_q  <= addr_err_s;
        valM_q <= (is_rd(icode_q) && !addr_err_s) ? rdata_s : '0;
      end
    end
  end

  // Storage commit; a reset on the access edge suppresses the write
  always_ff @(posedge clk_i) begin
    if (rst_n_i && do_access_s && is_wr(icode_q) && !addr_err_s) begin
      for (int i = 0; i < NB; i++) begin
        mem_q[idx_s + AW'(i)] <= wdata_s[8*i +: 8];
      end
    end
  end

  assign valM_o       = valM_q;
  assign icode_o      = icode_q;
  assign dmem_error_o = err_q;
endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: instance 0 runs WAIT=0, instance 1 runs WAIT=3; directed
// table, random traffic against a byte-array model, backpressure and mid-access reset.
module tb_dmem_stage;
  logic        clk;
  logic        rst_n     [2];
  logic        valid_in  [2];
  logic        ready_out [2];
  logic [3:0]  icode_in  [2];
  logic [63:0] va [2], ve [2], vp [2];
  logic        valid_out [2];
  logic        ready_in  [2];
  logic [63:0] valm      [2];
  logic [3:0]  icode_out [2];
  logic        err_out   [2];

  logic [7:0]  mem_m [2][1024];
  int          checks = 0;
  int          errors = 0;

  dmem_stage #(.DATA_W(64), .DEPTH_B(1024), .WAIT(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .valid_i(valid_in[0]), .ready_o(ready_out[0]),
    .icode_i(icode_in[0]), .valA_i(va[0]), .valE_i(ve[0]), .valP_i(vp[0]),
    .valid_o(valid_out[0]), .ready_i(ready_in[0]), .valM_o(valm[0]),
    .icode_o(icode_out[0]), .dmem_error_o(err_out[0]));

  dmem_stage #(.DATA_W(64), .DEPTH_B(1024), .WAIT(3)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .valid_i(valid_in[1]), .ready_o(ready_out[1]),
    .icode_i(icode_in[1]), .valA_i(va[1]), .valE_i(ve[1]), .valP_i(vp[1]),
    .valid_o(valid_out[1]), .ready_i(ready_in[1]), .valM_o(valm[1]),
    .icode_o(icode_out[1]), .dmem_error_o(err_out[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] a, e, p;
    logic [63:0] m;
    logic        err;
    int          lat;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: words are 8 little-endian bytes; out of range when addr > 1024-8
  task automatic model(input int k, input logic [3:0] ic, input logic [63:0] a, e, p,
                       output logic [63:0] em, output logic eerr, output int elat);
    logic [63:0] addr, wd;
    logic        wr, rd;
    wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    wd   = (ic == 4'h8) ? p : a;
    em   = 64'd0;
    eerr = (wr || rd) && (addr > 64'd1016);
    elat = (wr || rd) ? ((k == 0) ? 2 : 5) : 1;
    if (!eerr && rd) begin
      for (int i = 0; i < 8; i++) em = em | (64'(mem_m[k][int'(addr[9:0]) + i]) << (8 * i));
    end
    if (!eerr && wr) begin
      for (int i = 0; i < 8; i++) mem_m[k][int'(addr[9:0]) + i] = wd[8*i +: 8];
    end
  endtask

  // Issue one request from posedge+1, wait for the result, hold it for 'hold' cycles, release
  task automatic do_req(input int k, input logic [3:0] ic, input logic [63:0] a, e, p,
                        input logic [63:0] em, input logic eerr, input int elat, input int hold);
    int lat;
    valid_in[k] = 1'b1; icode_in[k] = ic; va[k] = a; ve[k] = e; vp[k] = p;
    chk("ready_before_accept", 64'(ready_out[k]), 64'd1);
    @(posedge clk); #1;
    valid_in[k] = 1'b0; icode_in[k] = 4'(($urandom));
    va[k] = {$urandom, $urandom}; ve[k] = {$urandom, $urandom}; vp[k] = {$urandom, $urandom};
    lat = 1;
    while (!valid_out[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("valM", valm[k], em);
    chk("dmem_error", 64'(err_out[k]), 64'(eerr));
    chk("icode_out", 64'(icode_out[k]), 64'(ic));
    for (int h = 0; h < hold; h++) begin
      valid_in[k] = 1'b1; icode_in[k] = 4'h5; ve[k] = 64'(h * 8);
      @(posedge clk); #1;
      chk("hold_valid", 64'(valid_out[k]), 64'd1);
      chk("hold_ready", 64'(ready_out[k]), 64'd0);
      chk("hold_valM", valm[k], em);
      chk("hold_icode", 64'(icode_out[k]), 64'(ic));
    end
    valid_in[k] = 1'b0;
    ready_in[k] = 1'b1;
    @(posedge clk); #1;
    ready_in[k] = 1'b0;
    chk("release_valid", 64'(valid_out[k]), 64'd0);
    chk("release_ready", 64'(ready_out[k]), 64'd1);
  endtask

  function automatic logic [63:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 64'(1017 + $urandom_range(0, 6));
    if (r == 1) return {$urandom, $urandom};
    return 64'($urandom_range(0, 1023));
  endfunction

  task automatic random_phase(input int k, input int n);
    logic [3:0]  codes [9];
    logic [3:0]  ic;
    logic [63:0] a, e, p, em;
    logic        eerr;
    int          elat;
    codes = '{4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'h7, 4'h5};
    for (int i = 0; i < n; i++) begin
      ic = codes[$urandom_range(0, 8)];
      a  = pick_addr();
      e  = pick_addr();
      p  = {$urandom, $urandom};
      model(k, ic, a, e, p, em, eerr, elat);
      do_req(k, ic, a, e, p, em, eerr, elat, $urandom_range(0, 2));
    end
  endtask

  initial begin
    logic [63:0] em;
    logic        eerr;
    int          elat;

    tbl[0]  = '{4'h4, 64'h80, 64'h0, 64'h0, 64'h0, 1'b0, 2};
    tbl[1]  = '{4'h5, 64'h0, 64'h0, 64'h0, 64'h80, 1'b0, 2};
    tbl[2]  = '{4'hA, 64'h1122334455667788, 64'h10, 64'h0, 64'h0, 1'b0, 2};
    tbl[3]  = '{4'hB, 64'h10, 64'h999, 64'h0, 64'h1122334455667788, 1'b0, 2};
    tbl[4]  = '{4'h5, 64'h0, 64'h11, 64'h0, 64'h0011223344556677, 1'b0, 2};
    tbl[5]  = '{4'h9, 64'h11, 64'h0, 64'h0, 64'h0011223344556677, 1'b0, 2};
    tbl[6]  = '{4'h8, 64'h77, 64'h3F8, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, 2};
    tbl[7]  = '{4'h4, 64'h5555, 64'h3FC, 64'h0, 64'h0, 1'b1, 2};
    tbl[8]  = '{4'h5, 64'h0, 64'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 2};
    tbl[9]  = '{4'h6, 64'h3, 64'h4, 64'h5, 64'h0, 1'b0, 1};
    tbl[10] = '{4'h5, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1'b1, 2};
    tbl[11] = '{4'hB, 64'h3F9, 64'h0, 64'h0, 64'h0, 1'b1, 2};
    tbl[12] = '{4'h7, 64'h0, 64'h10, 64'h0, 64'h0, 1'b0, 1};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) mem_m[k][i] = 8'h00;
      rst_n[k] = 1'b0; valid_in[k] = 1'b0; ready_in[k] = 1'b0; icode_in[k] = 4'h0;
      va[k] = 64'h0; ve[k] = 64'h0; vp[k] = 64'h0;
    end
    clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 64'(ready_out[k]), 64'd1);
      chk("reset_valid", 64'(valid_out[k]), 64'd0);
      chk("reset_valM", valm[k], 64'd0);
      chk("reset_icode", 64'(icode_out[k]), 64'd0);
      chk("reset_err", 64'(err_out[k]), 64'd0);
    end

    for (int i = 0; i < 13; i++) begin
      model(0, tbl[i].ic, tbl[i].a, tbl[i].e, tbl[i].p, em, eerr, elat);
      do_req(0, tbl[i].ic, tbl[i].a, tbl[i].e, tbl[i].p, tbl[i].m, tbl[i].err, tbl[i].lat, 0);
    end
    random_phase(0, 40);

    // Backpressure with WAIT=3
    model(1, 4'h4, 64'h0102030405060708, 64'h40, 64'h0, em, eerr, elat);
    do_req(1, 4'h4, 64'h0102030405060708, 64'h40, 64'h0, 64'h0, 1'b0, 5, 0);
    model(1, 4'h5, 64'h0, 64'h40, 64'h0, em, eerr, elat);
    do_req(1, 4'h5, 64'h0, 64'h40, 64'h0, 64'h0102030405060708, 1'b0, 5, 4);

    // Reset during the second ACCESS cycle discards the pending write
    model(1, 4'h4, 64'h1234, 64'h20, 64'h0, em, eerr, elat);
    do_req(1, 4'h4, 64'h1234, 64'h20, 64'h0, 64'h0, 1'b0, 5, 0);
    valid_in[1] = 1'b1; icode_in[1] = 4'h4; va[1] = 64'hFF; ve[1] = 64'h20;
    @(posedge clk); #1;
    valid_in[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    chk("midreset_valid", 64'(valid_out[1]), 64'd0);
    chk("midreset_ready", 64'(ready_out[1]), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("midreset_still_idle", 64'(valid_out[1]), 64'd0);
    model(1, 4'h5, 64'h0, 64'h20, 64'h0, em, eerr, elat);
    do_req(1, 4'h5, 64'h0, 64'h20, 64'h0, 64'h1234, 1'b0, 5, 0);

    random_phase(1, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
